// File: rtl/dcache_write_buffer.sv
// In-order write buffer between the dcache write port and the AXI bridge.
// Buffered writes are held in a circular FIFO; reads to a buffered line are held back.

module dcwb_line_cmp (
  input  logic        vld_i,
  input  logic [27:0] line_i,
  input  logic [27:0] probe_i,
  output logic        hit_o
);
  assign hit_o = vld_i && (line_i == probe_i);
endmodule

module dcache_write_buffer #(
  parameter int LOG2_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_wr_req,
  input  logic [2:0]   in_wr_type,
  input  logic [31:0]  in_wr_addr,
  input  logic [3:0]   in_wr_wstrb,
  input  logic [127:0] in_wr_data,
  output logic         in_wr_rdy,
  output logic         out_wr_req,
  output logic [2:0]   out_wr_type,
  output logic [31:0]  out_wr_addr,
  output logic [3:0]   out_wr_wstrb,
  output logic [127:0] out_wr_data,
  input  logic         out_wr_rdy,
  input  logic         in_rd_req,
  input  logic [31:0]  in_rd_addr,
  output logic         in_rd_rdy,
  output logic         out_rd_req,
  input  logic         out_rd_rdy,
  output logic         rd_hazard,
  output logic         empty
);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  typedef struct packed {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wb_entry_t;

  wb_entry_t [DEPTH-1:0]  mem_q;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [LOG2_DEPTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [LOG2_DEPTH:0]    count_q, count_d;

  logic      push, pop;
  wb_entry_t wr_ent, head_ent;

  assign wr_ent    = '{typ: in_wr_type, addr: in_wr_addr, wstrb: in_wr_wstrb, data: in_wr_data};
  assign in_wr_rdy = (count_q != {1'b1, {LOG2_DEPTH{1'b0}}});
  assign push      = in_wr_req && in_wr_rdy;
  assign pop       = out_wr_req && out_wr_rdy;

  // Head fields come straight from storage; held stable because a full
  // buffer never accepts a write into the slot being presented.
  assign head_ent     = mem_q[head_q];
  assign out_wr_req   = valid_q[head_q];
  assign out_wr_type  = head_ent.typ;
  assign out_wr_addr  = head_ent.addr;
  assign out_wr_wstrb = head_ent.wstrb;
  assign out_wr_data  = head_ent.data;
  assign empty        = (count_q == '0);

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= wr_ent;
    end
  end

  // Line-granular RAW check: every buffered entry plus the write accepted this cycle.
  logic [DEPTH-1:0] ent_hit;
  logic             in_hit;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    dcwb_line_cmp u_cmp (
      .vld_i   (valid_q[g]),
      .line_i  (mem_q[g].addr[31:4]),
      .probe_i (in_rd_addr[31:4]),
      .hit_o   (ent_hit[g])
    );
  end

  dcwb_line_cmp u_cmp_in (
    .vld_i   (push),
    .line_i  (in_wr_addr[31:4]),
    .probe_i (in_rd_addr[31:4]),
    .hit_o   (in_hit)
  );

  assign rd_hazard  = (|ent_hit) || in_hit;
  assign out_rd_req = in_rd_req && !rd_hazard;
  assign in_rd_rdy  = out_rd_rdy && !rd_hazard;

  logic unused_lo;
  assign unused_lo = ^{in_rd_addr[3:0], in_wr_addr[3:0]};

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed plus randomized bench for dcache_write_buffer against a queue-based model.

module tb_dcache_write_buffer;
  localparam int LOG2_DEPTH = 2;
  localparam int DEPTH      = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_wr_req;
  logic [2:0]   in_wr_type;
  logic [31:0]  in_wr_addr;
  logic [3:0]   in_wr_wstrb;
  logic [127:0] in_wr_data;
  logic         in_wr_rdy;
  logic         out_wr_req;
  logic [2:0]   out_wr_type;
  logic [31:0]  out_wr_addr;
  logic [3:0]   out_wr_wstrb;
  logic [127:0] out_wr_data;
  logic         out_wr_rdy;
  logic         in_rd_req;
  logic [31:0]  in_rd_addr;
  logic         in_rd_rdy;
  logic         out_rd_req;
  logic         out_rd_rdy;
  logic         rd_hazard;
  logic         empty;

  dcache_write_buffer #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_wr_req(in_wr_req), .in_wr_type(in_wr_type), .in_wr_addr(in_wr_addr),
    .in_wr_wstrb(in_wr_wstrb), .in_wr_data(in_wr_data), .in_wr_rdy(in_wr_rdy),
    .out_wr_req(out_wr_req), .out_wr_type(out_wr_type), .out_wr_addr(out_wr_addr),
    .out_wr_wstrb(out_wr_wstrb), .out_wr_data(out_wr_data), .out_wr_rdy(out_wr_rdy),
    .in_rd_req(in_rd_req), .in_rd_addr(in_rd_addr), .in_rd_rdy(in_rd_rdy),
    .out_rd_req(out_rd_req), .out_rd_rdy(out_rd_rdy),
    .rd_hazard(rd_hazard), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [3:0]   s;
    logic [127:0] d;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:4] == b[31:4];
  endfunction

  // Expected outputs derived from the queue contents and current inputs.
  task automatic check_model();
    bit acc, haz;
    acc = (q.size() < DEPTH);
    haz = 1'b0;
    foreach (q[i]) if (same_line(q[i].a, in_rd_addr)) haz = 1'b1;
    if (in_wr_req && acc && same_line(in_wr_addr, in_rd_addr)) haz = 1'b1;
    chk("in_wr_rdy", in_wr_rdy, acc);
    chk("empty", empty, q.size() == 0);
    chk("out_wr_req", out_wr_req, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_wr_addr", out_wr_addr, q[0].a);
      chk("out_wr_type", out_wr_type, q[0].t);
      chk("out_wr_wstrb", out_wr_wstrb, q[0].s);
      chk("out_wr_data", out_wr_data, q[0].d);
    end
    chk("rd_hazard", rd_hazard, haz);
    chk("out_rd_req", out_rd_req, in_rd_req && !haz);
    chk("in_rd_rdy", in_rd_rdy, out_rd_rdy && !haz);
  endtask

  task automatic cycle();
    bit push, pop;
    @(negedge clk);
    check_model();
    push = in_wr_req && (q.size() < DEPTH);
    pop  = (q.size() != 0) && out_wr_rdy;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data});
    #1;
  endtask

  task automatic set_wr(input logic req, input logic [2:0] t, input logic [31:0] a,
                        input logic [3:0] s, input logic [127:0] d);
    in_wr_req   = req;
    in_wr_type  = t;
    in_wr_addr  = a;
    in_wr_wstrb = s;
    in_wr_data  = d;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_a;
    logic [2:0]  tsel [4];
    tsel = '{3'b000, 3'b001, 3'b010, 3'b100};

    // Reset state
    reset = 1'b1;
    set_wr(1'b0, 3'b0, 32'h0, 4'h0, 128'h0);
    out_wr_rdy = 1'b0;
    in_rd_req  = 1'b0;
    in_rd_addr = 32'h0;
    out_rd_rdy = 1'b1;
    #1;
    chk("rst_in_wr_rdy", in_wr_rdy, 1'b1);
    chk("rst_out_wr_req", out_wr_req, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_rd_hazard", rd_hazard, 1'b0);
    chk("rst_out_rd_req", out_rd_req, 1'b0);
    chk("rst_in_rd_rdy", in_rd_rdy, 1'b1);
    chk("rst_out_wr_addr", out_wr_addr, 32'h0);
    chk("rst_out_wr_data", out_wr_data, 128'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle();
    cycle();

    // Single line write, drained immediately
    out_wr_rdy = 1'b1;
    set_wr(1'b1, 3'b100, 32'h1C000040, 4'hF, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    cycle();
    in_wr_req = 1'b0;
    chk("single_req", out_wr_req, 1'b1);
    chk("single_addr", out_wr_addr, 32'h1C000040);
    chk("single_data", out_wr_data, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    chk("single_type", out_wr_type, 3'b100);
    cycle();
    chk("single_empty", empty, 1'b1);
    cycle();

    // Fill with the bridge stalled, then drain in order
    out_wr_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_wr(1'b1, 3'b010, 32'h100 * i, 4'hF, rnd128());
      cycle();
    end
    chk("full_rdy", in_wr_rdy, 1'b0);
    set_wr(1'b1, 3'b010, 32'h500, 4'hF, rnd128());
    cycle();
    chk("full_reject_rdy", in_wr_rdy, 1'b0);
    chk("full_reject_head", out_wr_addr, 32'h100);
    in_wr_req  = 1'b0;
    out_wr_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_a = 32'h100 * i;
      chk("drain_order", out_wr_addr, exp_a);
      cycle();
    end
    chk("drain_empty", empty, 1'b1);

    // Simultaneous push and pop at count 2, then refill past the wrap point
    out_wr_rdy = 1'b0;
    set_wr(1'b1, 3'b000, 32'h600, 4'h1, rnd128()); cycle();
    set_wr(1'b1, 3'b001, 32'h700, 4'h3, rnd128()); cycle();
    out_wr_rdy = 1'b1;
    set_wr(1'b1, 3'b010, 32'h800, 4'hF, rnd128()); cycle();
    out_wr_rdy = 1'b0;
    chk("pp_head", out_wr_addr, 32'h700);
    set_wr(1'b1, 3'b000, 32'h900, 4'h2, rnd128()); cycle();
    set_wr(1'b1, 3'b000, 32'hA00, 4'h4, rnd128()); cycle();
    chk("pp_full_after_two", in_wr_rdy, 1'b0);
    in_wr_req  = 1'b0;
    out_wr_rdy = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("pp_empty", empty, 1'b1);

    // RAW hazard against a buffered entry
    out_wr_rdy = 1'b0;
    set_wr(1'b1, 3'b010, 32'h80001230, 4'hF, rnd128()); cycle();
    in_wr_req  = 1'b0;
    in_rd_req  = 1'b1;
    in_rd_addr = 32'h8000123C;
    cycle();
    chk("haz_hit", rd_hazard, 1'b1);
    chk("haz_out_rd_req", out_rd_req, 1'b0);
    chk("haz_in_rd_rdy", in_rd_rdy, 1'b0);
    in_rd_addr = 32'h80001240;
    cycle();
    chk("haz_other_line", out_rd_req, 1'b1);
    in_rd_addr = 32'h8000123C;
    out_wr_rdy = 1'b1;
    cycle();
    chk("haz_cleared", out_rd_req, 1'b1);
    in_rd_req = 1'b0;

    // Same-cycle hazard with an incoming write
    set_wr(1'b1, 3'b010, 32'h500, 4'hF, rnd128());
    in_rd_req  = 1'b1;
    in_rd_addr = 32'h504;
    #1;
    chk("samecyc_haz", rd_hazard, 1'b1);
    chk("samecyc_out_rd_req", out_rd_req, 1'b0);
    cycle();
    in_wr_req = 1'b0;
    in_rd_req = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a drain
    out_wr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, 3'b100, 32'hC000_0000 + 32'h10 * i, 4'hF, rnd128());
      cycle();
    end
    in_wr_req  = 1'b0;
    out_wr_rdy = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_out_wr_req", out_wr_req, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_in_wr_rdy", in_wr_rdy, 1'b1);
    chk("mid_rst_out_wr_addr", out_wr_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle();

    // Randomized traffic over a small pool of lines so hazards occur often
    for (int n = 0; n < 600; n++) begin
      set_wr(1'($urandom_range(0, 1)), tsel[$urandom_range(0, 3)],
             32'hA000_0000 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15),
             4'($urandom), rnd128());
      out_wr_rdy = 1'($urandom_range(0, 2) != 0);
      in_rd_req  = 1'($urandom_range(0, 1));
      in_rd_addr = 32'hA000_0000 | ($urandom_range(0, 9) << 4) | $urandom_range(0, 15);
      out_rd_rdy = 1'($urandom_range(0, 1));
      cycle();
    end
    in_wr_req  = 1'b0;
    out_wr_rdy = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("final_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- FIFO write buffer between the dcache write port and the AXI bridge's dcache write port.
- Absorbs dirty-line writebacks (128-bit) and uncached stores so the dcache can proceed without waiting for AXI write completion.
- Drains entries in order to the bridge.
- Gates dcache read requests whose line address matches a pending write (RAW hazard), so a refill never bypasses an older writeback.

Parameters:
- LOG2_DEPTH, 2, log2 of entry count; DEPTH = 2**LOG2_DEPTH; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_wr_req  in  1  dcache write request
- in_wr_type  in  3  3'b100 = line (4 words), else size code (3'b000/001/010)
- in_wr_addr  in  32  write address
- in_wr_wstrb  in  4  byte strobes (meaningful for non-line types)
- in_wr_data  in  128  write data; word 0 in [31:0]
- in_wr_rdy  out  1  buffer can accept; transfer when in_wr_req && in_wr_rdy
- out_wr_req  out  1  head entry valid, to bridge
- out_wr_type  out  3  head entry type
- out_wr_addr  out  32  head entry address
- out_wr_wstrb  out  4  head entry strobes
- out_wr_data  out  128  head entry data
- out_wr_rdy  in  1  bridge ready; pop when out_wr_req && out_wr_rdy
- in_rd_req  in  1  dcache read request
- in_rd_addr  in  32  dcache read address
- in_rd_rdy  out  1  read ready returned to dcache
- out_rd_req  out  1  read request forwarded to bridge
- out_rd_rdy  in  1  bridge read ready
- rd_hazard  out  1  in_rd_addr line matches a pending or incoming write
- empty  out  1  no valid entries (used by dcache for ordering/fence)

Behaviour:
- Storage: DEPTH entries of {type, addr, wstrb, data}, plus valid bits.
- Pointers: head and tail pointers, each LOG2_DEPTH bits, wrapping modulo DEPTH; count register of LOG2_DEPTH+1 bits.
- Reset (async, active-high): count=0, head=tail=0, all valid=0.
  - Outputs after reset: in_wr_rdy=1, out_wr_req=0, empty=1, rd_hazard=0, out_rd_req=0, in_rd_rdy=out_rd_rdy.
  - out_wr_* data/addr/type/wstrb = 0.
  - Reset mid-drain discards all entries; no partial state survives.
- in_wr_rdy = (count != DEPTH). No write-through when full, even if a pop occurs in the same cycle.
- Push: on in_wr_req && in_wr_rdy, store the entry at tail, set valid[tail], tail++.
- out_wr_* are driven directly from the head entry, i.e. from registers.
  - out_wr_req = valid[head].
  - Latency: a push in cycle N is visible as out_wr_req in cycle N+1 at the earliest.
- Pop: on out_wr_req && out_wr_rdy, clear valid[head], head++. The next entry is presented in the following cycle.
- Bridge contract: the bridge samples out_wr_* in the accept cycle. The buffer must hold out_wr_* stable while out_wr_req=1 and out_wr_rdy=0.
- Simultaneous push and pop: both occur and count is unchanged. When count=1, the head advances to the freshly pushed entry.
- count: +1 on push only, -1 on pop only. Never exceeds DEPTH and never underflows; pop is impossible when empty.
- empty = (count == 0), registered-equivalent.
- Hazard check:
  - Line match means addr[31:4] equal.
  - rd_hazard = OR over valid entries of line match with in_rd_addr, OR (in_wr_req && in_wr_rdy && line match with in_wr_addr).
  - rd_hazard is combinational and independent of in_rd_req.
  - The check is conservative: word-sized entries are also compared at line granularity.
- Read gating:
  - out_rd_req = in_rd_req && !rd_hazard.
  - in_rd_rdy = out_rd_rdy && !rd_hazard.
  - The read address passes to the bridge unchanged, outside this block.
- A hazard clears only when the matching entry pops. The bridge itself blocks reads until its write response completes.
- Ordering: writes drain strictly in push order. Reads to non-matching lines may overtake buffered writes.

Test Plan:
- Reset then idle: in_wr_rdy=1, empty=1, out_wr_req=0. Assert reset mid-drain with 3 entries -> count=0 and out_wr_req=0 immediately (async).
- Single push, line write, addr 0x1C000040, data 128'h4444_3333_2222_1111…, out_wr_rdy=1 -> out_wr_req=1 one cycle later with identical fields; popped in that cycle; empty=1 in the cycle after.
- Fill with out_wr_rdy=0: push 4 entries (addrs 0x100,0x200,0x300,0x400) -> in_wr_rdy=0 after the 4th. A 5th in_wr_req is not accepted. Release out_wr_rdy -> pops in order 0x100,0x200,0x300,0x400.
- Simultaneous push and pop at count=2 -> count stays 2. Pointer wrap after 6 total pushes with DEPTH=4 preserves order.
- Hazard: buffer holds 0x80001230 -> in_rd_req at 0x8000123C gives rd_hazard=1, out_rd_req=0, in_rd_rdy=0. Read at 0x80001240 -> out_rd_req=1. After the entry pops, the 0x8000123C read is forwarded.
- Same-cycle hazard: empty buffer, in_wr_req at 0x500 and in_rd_req at 0x504 in one cycle -> rd_hazard=1 and out_rd_req=0.
